// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use interlock, multi-cycle multiply
// sequencing and wrong-path flush on taken branches. Optional counters behind `HAZ_STAT_EN.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       id_mul_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic       branch_taken_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_flush_o,
  output logic       exmem_flush_o,
  output logic       mul_start_o,
  output logic       mul_busy_o,
  output logic [1:0] state_o
`ifdef HAZ_STAT_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_done_q, mul_done_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, mul_start;

  // A load into $0 never produces a value worth waiting for.
  assign load_use = ex_memread_i & (ex_rt_i != 5'd0) &
                    ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mul_start   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_done_d  = mul_done_q;

    if (branch_taken_i) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
      mul_done_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (id_mul_i && !mul_done_q) begin
            mul_start  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_d      = CNT_INIT;
            state_d    = MUL_WAIT;
          end else if (id_mul_i && mul_done_q) begin
            // Result is ready: let the multiply issue into EX this cycle.
            mul_done_d = 1'b0;
          end
        end
        MUL_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d    = RUN;
            mul_done_d = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mul_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_done_q <= mul_done_d;
    end
  end

  // Reset forces a free-running, flush-free pipeline regardless of the inputs.
  assign pc_write_o    = rst_i | pc_write;
  assign ifid_write_o  = rst_i | ifid_write;
  assign ifid_flush_o  = ~rst_i & ifid_flush;
  assign idex_flush_o  = ~rst_i & idex_flush;
  assign exmem_flush_o = ~rst_i & exmem_flush;
  assign mul_start_o   = ~rst_i & mul_start;
  assign mul_busy_o    = ~rst_i & (state_q == MUL_WAIT);
  assign state_o       = state_q;

`ifdef HAZ_STAT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (branch_taken_i && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MUL_LAT = 4): each task drives one scenario and
// compares the packed output vector cycle by cycle against hand-computed values.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_uses_rt_i, id_mul_i, ex_memread_i, branch_taken_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic       mul_start_o, mul_busy_o;
  logic [1:0] state_o;
`ifdef HAZ_STAT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // obs = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, mul_start, mul_busy, state[1:0]}
  logic [8:0] obs;
  assign obs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
                mul_start_o, mul_busy_o, state_o};

  localparam logic [8:0] IDLE   = 9'b11_000_00_00;
  localparam logic [8:0] STALL  = 9'b00_010_00_00;
  localparam logic [8:0] MSTART = 9'b00_010_10_00;
  localparam logic [8:0] MWAIT  = 9'b00_010_01_10;
  localparam logic [8:0] BR     = 9'b11_111_00_00;
  localparam logic [8:0] ALL    = 9'h1FF;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_mul_i(id_mul_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .mul_start_o(mul_start_o), .mul_busy_o(mul_busy_o), .state_o(state_o)
`ifdef HAZ_STAT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic set_idle();
    id_rs_i = 5'd1; id_rt_i = 5'd2; id_uses_rt_i = 1'b0; id_mul_i = 1'b0;
    ex_memread_i = 1'b0; ex_rt_i = 5'd3; branch_taken_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    id_rs_i = 5'd8; ex_rt_i = 5'd8; ex_memread_i = 1'b1; id_mul_i = 1'b1;
    branch_taken_i = 1'b1; id_uses_rt_i = 1'b1; id_rt_i = 5'd8;
    repeat (2) @(negedge clk_i);
    #1;
    total_cnt++;
    if (obs !== IDLE) begin
      fail_cnt++; $display("FAIL reset_hold: got %b want %b", obs, IDLE);
    end else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0; set_idle();
    #1;
    total_cnt++;
    if (obs !== IDLE) begin
      fail_cnt++; $display("FAIL reset_release: got %b want %b", obs, IDLE);
    end else pass_cnt++;
  endtask

  task automatic test_load_use();
    logic [8:0] exp_v [4] = '{STALL, IDLE, IDLE, IDLE};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      set_idle();
      if (i == 0) begin ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8; end
      if (i == 2) begin ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0; end
      if (i == 3) begin ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd7; end
      #1;
      total_cnt++;
      if (obs !== exp_v[i]) begin
        fail_cnt++; $display("FAIL load_use cyc%0d: got %b want %b", i, obs, exp_v[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_rt_gating();
    logic [8:0] exp_v [3] = '{IDLE, STALL, IDLE};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      set_idle();
      if (i < 2) begin
        ex_memread_i = 1'b1; ex_rt_i = 5'd9; id_rt_i = 5'd9; id_rs_i = 5'd4;
        id_uses_rt_i = (i == 1);
      end
      #1;
      total_cnt++;
      if (obs !== exp_v[i]) begin
        fail_cnt++; $display("FAIL rt_gating cyc%0d: got %b want %b", i, obs, exp_v[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    logic [8:0] exp_v [6] = '{MSTART, MWAIT, MWAIT, MWAIT, IDLE, IDLE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      set_idle();
      id_mul_i = (i < 5);
      #1;
      total_cnt++;
      if (obs !== exp_v[i]) begin
        fail_cnt++; $display("FAIL mul cyc%0d: got %b want %b", i, obs, exp_v[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_branch_run();
    @(negedge clk_i);
    set_idle(); branch_taken_i = 1'b1; id_mul_i = 1'b1;
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5;
    #1;
    total_cnt++;
    if (obs !== BR) begin
      fail_cnt++; $display("FAIL branch_run: got %b want %b", obs, BR);
    end else pass_cnt++;
  endtask

  task automatic test_branch_abort();
    // Entries flagged in msk_v only compare the bits that the branch defines.
    logic [8:0] exp_v [8] = '{MSTART, MWAIT, 9'b10_111_00_00, MSTART, MWAIT, MWAIT, MWAIT, IDLE};
    logic [8:0] msk_v [8] = '{ALL, ALL, 9'b10_111_10_00, ALL, ALL, ALL, ALL, ALL};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      set_idle();
      id_mul_i = 1'b1;
      branch_taken_i = (i == 2);
      #1;
      total_cnt++;
      if ((obs & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
        fail_cnt++;
        $display("FAIL branch_abort cyc%0d: got %b want %b", i, obs & msk_v[i], exp_v[i] & msk_v[i]);
      end else pass_cnt++;
    end
    @(negedge clk_i);
    set_idle();
  endtask

  task automatic test_priority();
    logic [8:0] exp_v [6] = '{STALL, MSTART, MWAIT, MWAIT, MWAIT, IDLE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      set_idle();
      id_mul_i = 1'b1;
      if (i == 0) begin ex_memread_i = 1'b1; ex_rt_i = 5'd12; id_rs_i = 5'd12; end
      #1;
      total_cnt++;
      if (obs !== exp_v[i]) begin
        fail_cnt++; $display("FAIL priority cyc%0d: got %b want %b", i, obs, exp_v[i]);
      end else pass_cnt++;
    end
    @(negedge clk_i);
    set_idle();
  endtask

  task automatic test_async_reset();
    logic [8:0] exp_v [5] = '{MSTART, MWAIT, MWAIT, MWAIT, IDLE};
    @(negedge clk_i);
    set_idle(); id_mul_i = 1'b1;
    @(negedge clk_i);
    #1;
    total_cnt++;
    if (obs !== MWAIT) begin
      fail_cnt++; $display("FAIL async_pre: got %b want %b", obs, MWAIT);
    end else pass_cnt++;
    #1 rst_i = 1'b1;
    #1;
    total_cnt++;
    if (obs !== IDLE) begin
      fail_cnt++; $display("FAIL async_assert: got %b want %b", obs, IDLE);
    end else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0; set_idle();
    #1;
    total_cnt++;
    if (obs !== IDLE) begin
      fail_cnt++; $display("FAIL async_release: got %b want %b", obs, IDLE);
    end else pass_cnt++;
    // mul_done_q must be clear: a fresh multiply takes the full stall again.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      set_idle(); id_mul_i = 1'b1;
      #1;
      total_cnt++;
      if (obs !== exp_v[i]) begin
        fail_cnt++; $display("FAIL async_restart cyc%0d: got %b want %b", i, obs, exp_v[i]);
      end else pass_cnt++;
    end
    @(negedge clk_i);
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_mul();
    test_branch_run();
    test_branch_abort();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards, sequences a multi-cycle multiplier occupying EX, and flushes wrong-path instructions on taken branches resolved in MEM.
- Drives PC write-enable, IF/ID write-enable and the IF/ID, ID/EX and EX/MEM flush controls.
- Sits beside the decode stage; consumes register fields decoded in ID and control bits from the EX/MEM pipeline registers.

Parameters:
- MUL_LAT, 4: total pipeline stall cycles for one multiply; legal range 2..15.
- CNT_W, 4: width of the multiply countdown counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- id_rs_i  input  5  rs field of the instruction in ID.
- id_rt_i  input  5  rt field of the instruction in ID.
- id_uses_rt_i  input  1  instruction in ID reads rt as a source.
- id_mul_i  input  1  instruction in ID is a multiply.
- ex_memread_i  input  1  instruction in EX is a load.
- ex_rt_i  input  5  destination rt of the instruction in EX.
- branch_taken_i  input  1  branch resolved taken in MEM.
- pc_write_o  output  1  PC update enable.
- ifid_write_o  output  1  IF/ID register write enable.
- ifid_flush_o  output  1  zero IF/ID contents.
- idex_flush_o  output  1  insert bubble into ID/EX (zero control bits).
- exmem_flush_o  output  1  zero EX/MEM control bits.
- mul_start_o  output  1  one-cycle start pulse to the multiplier.
- mul_busy_o  output  1  high while in MUL_WAIT.
- state_o  output  2  current state: 0 = RUN, 2 = MUL_WAIT.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset state: state = RUN, cnt = 0, mul_done_q = 0.
- Outputs while rst_i is high: pc_write_o = 1, ifid_write_o = 1, all flushes = 0, mul_start_o = 0, mul_busy_o = 0, state_o = 0. This holds regardless of the other inputs.
- Outputs are combinational from state and inputs, so a stall or flush acts in the same cycle as detection. State, cnt and mul_done_q are registered.
- Hazard term: load_use = ex_memread_i & (ex_rt_i != 0) & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i))).
- Default outputs: pc_write = 1, ifid_write = 1, flushes = 0, mul_start = 0.
- Priority 1, branch_taken_i (any state):
  - ifid_flush, idex_flush and exmem_flush = 1; pc_write = 1.
  - Next state RUN, cnt <= 0, mul_done_q <= 0.
  - No mul_start, even if id_mul_i is high. Aborts MUL_WAIT.
- RUN, load_use:
  - pc_write = 0, ifid_write = 0, idex_flush = 1.
  - Stay in RUN. Load-use takes precedence over multiply start.
- RUN, id_mul_i & !mul_done_q:
  - mul_start = 1; pc_write = 0, ifid_write = 0, idex_flush = 1.
  - cnt <= MUL_LAT-2; next state MUL_WAIT.
- RUN, id_mul_i & mul_done_q:
  - No stall; the multiply issues into EX.
  - mul_done_q <= 0 at the clock edge.
- MUL_WAIT:
  - pc_write = 0, ifid_write = 0, idex_flush = 1, mul_busy = 1.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: next state RUN, mul_done_q <= 1.
- Total stall for one multiply = MUL_LAT cycles: 1 in RUN plus MUL_LAT-1 in MUL_WAIT. The multiply enters EX on the following cycle.
- load_use is ignored in MUL_WAIT. The instruction in EX is a bubble, and ex_memread_i from a bubble is 0.
- Reset asserted mid-MUL_WAIT returns immediately to RUN with mul_done_q = 0; the multiply is restarted after release.
- Register $0 never causes a stall.

Optional Feature:
- Macro HAZ_STAT_EN.
- Defined: adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0], both saturating at 16'hFFFF and cleared by rst_i.
  - stall_cnt_o increments every cycle pc_write_o = 0.
  - flush_cnt_o increments every cycle branch_taken_i causes a flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: ex_memread_i = 1, ex_rt_i = 8, id_rs_i = 8 for 1 cycle -> pc_write_o = 0, ifid_write_o = 0, idex_flush_o = 1 that cycle only. Repeat with ex_rt_i = 0 -> no stall.
- rt gating: ex_rt_i = 9 = id_rt_i, id_uses_rt_i = 0 -> no stall; with id_uses_rt_i = 1 -> 1-cycle stall.
- Multiply, MUL_LAT = 4, id_mul_i held high:
  - mul_start_o pulses once.
  - pc_write_o is low for exactly 4 cycles; mul_busy_o is high for 3.
  - state_o reads 0, 2, 2, 2, 0.
  - Cycle 5: no stall, no second mul_start_o.
- Branch abort: branch_taken_i = 1 in the 2nd MUL_WAIT cycle -> all three flushes high, pc_write_o = 1, state_o = 0 next cycle. Re-presenting id_mul_i restarts the full 4-cycle stall.
- Priority: load_use and id_mul_i both high in RUN -> stall without mul_start_o. Next cycle (load_use low) mul_start_o = 1.
- Async reset: assert rst_i mid-MUL_WAIT between clock edges -> outputs go to reset values immediately. After release, state_o = 0 and mul_done_q = 0.
